// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// The start bit is qualified at its midpoint. Every later bit is then sampled
// one full bit period after the previous sample. The FSM leaves STOP at the
// middle of the stop bit, so a start bit that follows immediately is still
// caught. A low stop bit raises a frame error. The FSM then waits for the
// line to return high before it looks for another start bit.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per UART bit (8..65535)
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   rx         : asynchronous serial input, idle high, LSB first
//   uart_data  : last correctly framed byte
//   uart_valid : one-cycle pulse when uart_data takes a new value
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   busy       : high whenever the receiver is not idle
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] uart_data,
    output logic       uart_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_sync;
    logic [CNT_W-1:0] counter;
    logic [2:0]       bit_index;
    logic [7:0]       shift_reg;

    // Both synchronizer flops reset high (the idle line level), so that
    // leaving reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Receive FSM. The pulse outputs default low on every cycle, so each one
    // lasts exactly one cycle. busy is updated on every state change and
    // therefore always matches (state != IDLE).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            bit_index  <= '0;
            shift_reg  <= '0;
            uart_data  <= '0;
            uart_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            uart_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state   <= START;
                        counter <= '0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (counter == HALF_LAST) begin
                        counter   <= '0;
                        bit_index <= '0;
                        if (!rx_sync) begin
                            state <= DATA;
                        end else begin
                            // The line went high again before mid-bit: treat it as a glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                DATA: begin
                    if (counter == BIT_LAST) begin
                        counter              <= '0;
                        shift_reg[bit_index] <= rx_sync;
                        if (bit_index == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_index <= bit_index + 1'b1;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                STOP: begin
                    if (counter == BIT_LAST) begin
                        counter <= '0;
                        if (rx_sync) begin
                            uart_data  <= shift_reg;
                            uart_valid <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK_WAIT;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    // A low line here is a break or a bad frame, not a start bit.
                    if (rx_sync) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
